// File: rtl/time_set_controller.sv
// -----------------------------------------------------------------------------
// time_set_controller
//
// Front-panel controller for setting a clock's minutes and hours with two
// active-low push keys.  Both keys are synchronized and debounced.  Mode-key
// presses step the mode SHOW -> SET_MIN -> SET_HOUR -> STOP -> SHOW.
// Add-key presses, plus auto-repeat while the key is held, issue minute or
// hour increment pulses in the two SET modes.  The digit pair being edited
// blinks.  This block only issues commands: the minute/hour values and their
// wrap-around are kept by the datapath.
//
// Parameters
//   DEBOUNCE_CYCLES  clocks a synchronized key level must differ from the
//                    filtered level before it is accepted (2..65535)
//   REPEAT_DELAY     ticks the add key is held before auto-repeat (1..255)
//   REPEAT_RATE      ticks between auto-repeat increments          (1..255)
//   BLINK_TICKS      ticks per blink half-period                   (1..255)
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous, active-low reset
//   i_key_mode      raw mode key, active-low, asynchronous
//   i_key_add       raw add key, active-low, asynchronous
//   i_tick_in       one-clock timebase pulse (the seconds tick)
//   o_mode          0=SHOW 1=SET_MIN 2=SET_HOUR 3=STOP
//   o_run_enable    1 only in SHOW; lets the time counters run
//   o_minute_inc    one-clock pulse: advance minute, no carry into hour
//   o_hour_inc      one-clock pulse: advance hour
//   o_second_clear  one-clock pulse: zero the seconds counter
//   o_blank_minute  1 = blank the minute digits
//   o_blank_hour    1 = blank the hour digits
// -----------------------------------------------------------------------------
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_RATE     = 2,
  parameter int unsigned BLINK_TICKS     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_key_mode,
  input  logic       i_key_add,
  input  logic       i_tick_in,
  output logic [1:0] o_mode,
  output logic       o_run_enable,
  output logic       o_minute_inc,
  output logic       o_hour_inc,
  output logic       o_second_clear,
  output logic       o_blank_minute,
  output logic       o_blank_hour
);

  localparam logic [1:0] S_SHOW     = 2'd0;
  localparam logic [1:0] S_SET_MIN  = 2'd1;
  localparam logic [1:0] S_SET_HOUR = 2'd2;
  localparam logic [1:0] S_STOP     = 2'd3;

  localparam int unsigned K_MODE = 0;
  localparam int unsigned K_ADD  = 1;

  localparam int unsigned        DBW        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0]     DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]         REP_DELAY  = 8'(REPEAT_DELAY);
  localparam logic [7:0]         REP_RATE   = 8'(REPEAT_RATE);
  localparam logic [7:0]         BLINK_LAST = 8'(BLINK_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Key conditioning: 2-flop synchronizer, debounce filter, press detect.
  // Index K_MODE / K_ADD.  Levels are active-low, so 1 = released.
  // ---------------------------------------------------------------------------
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_filt;
  logic [1:0]     r_filt_d;
  logic [1:0]     r_press;
  logic [DBW-1:0] r_db_cnt [2];

  // The filter accepts a new level on the DEBOUNCE_CYCLES-th consecutive
  // clock of disagreement.  The registered press stage then puts the
  // command outputs exactly DEBOUNCE_CYCLES+3 clocks after the first edge
  // that samples the new raw level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_filt   <= '1;
      r_filt_d <= '1;
      r_press  <= '0;
      for (int unsigned k = 0; k < 2; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      r_sync1  <= {i_key_add, i_key_mode};
      r_sync2  <= r_sync1;
      r_filt_d <= r_filt;
      r_press  <= r_filt_d & ~r_filt;
      for (int unsigned k = 0; k < 2; k++) begin
        if (r_sync2[k] == r_filt[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_filt[k]   <= r_sync2[k];
          r_db_cnt[k] <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM, increment generation, auto-repeat and blink.
  // ---------------------------------------------------------------------------
  logic [1:0] r_mode;
  logic       r_armed;
  logic       r_repeating;
  logic [7:0] r_rep_cnt;
  logic [7:0] r_blink_cnt;
  logic       r_phase;

  logic       w_mode_press;
  logic       w_add_press;
  logic       w_add_held;
  logic       w_set_mode;
  logic [1:0] w_mode_next;
  logic [7:0] w_rep_limit;
  logic       w_rep_fire;
  logic       w_inc;
  logic       w_phase_next;

  always_comb begin
    w_mode_press = r_press[K_MODE];
    w_add_press  = r_press[K_ADD];
    w_add_held   = ~r_filt[K_ADD];
    w_set_mode   = (r_mode != S_SHOW) && (r_mode != S_STOP);
    w_mode_next  = w_mode_press ? (r_mode + 2'd1) : r_mode;
    w_rep_limit  = r_repeating ? REP_RATE : REP_DELAY;
    w_rep_fire   = r_armed && w_add_held && i_tick_in &&
                   ((r_rep_cnt + 8'd1) == w_rep_limit);
    // A mode press in the same clock swallows any add action.
    w_inc        = !w_mode_press && w_set_mode && (w_add_press || w_rep_fire);
    w_phase_next = r_phase;
    if (w_inc) begin
      w_phase_next = 1'b0;
    end else if (i_tick_in && (r_blink_cnt == BLINK_LAST)) begin
      w_phase_next = ~r_phase;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mode         <= S_SHOW;
      r_armed        <= 1'b0;
      r_repeating    <= 1'b0;
      r_rep_cnt      <= '0;
      r_blink_cnt    <= '0;
      r_phase        <= 1'b0;
      o_run_enable   <= 1'b1;
      o_minute_inc   <= 1'b0;
      o_hour_inc     <= 1'b0;
      o_second_clear <= 1'b0;
      o_blank_minute <= 1'b0;
      o_blank_hour   <= 1'b0;
    end else begin
      r_mode         <= w_mode_next;
      o_run_enable   <= (w_mode_next == S_SHOW);
      o_second_clear <= w_mode_press && (w_mode_next == S_SET_MIN);
      o_minute_inc   <= w_inc && (r_mode == S_SET_MIN);
      o_hour_inc     <= w_inc && (r_mode == S_SET_HOUR);

      // Repeat is armed only by an accepted add press and dropped on any
      // release, mode change or non-editing mode.
      if (w_mode_press || !w_add_held || !w_set_mode) begin
        r_armed     <= 1'b0;
        r_repeating <= 1'b0;
        r_rep_cnt   <= '0;
      end else if (w_add_press) begin
        r_armed     <= 1'b1;
        r_repeating <= 1'b0;
        r_rep_cnt   <= '0;
      end else if (r_armed && i_tick_in) begin
        if (w_rep_fire) begin
          r_repeating <= 1'b1;
          r_rep_cnt   <= '0;
        end else begin
          r_rep_cnt   <= r_rep_cnt + 8'd1;
        end
      end

      // An increment restarts the blink so the edited digits show at once.
      if (w_inc) begin
        r_blink_cnt <= '0;
      end else if (i_tick_in) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt <= '0;
        end else begin
          r_blink_cnt <= r_blink_cnt + 8'd1;
        end
      end
      r_phase        <= w_phase_next;
      o_blank_minute <= w_phase_next && (w_mode_next == S_SET_MIN);
      o_blank_hour   <= w_phase_next && (w_mode_next == S_SET_HOUR);
    end
  end

  assign o_mode = r_mode;

endmodule

// File: tb/tb_time_set_controller.sv
// -----------------------------------------------------------------------------
// tb_time_set_controller
//
// Self-checking bench for time_set_controller with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=3, REPEAT_RATE=1, BLINK_TICKS=2 and a tick every 4 clocks.
// Expected pulses (minute_inc, hour_inc, second_clear) are queued with the
// cycle they must appear in; a monitor pops and compares them as the DUT
// produces pulses.
// -----------------------------------------------------------------------------
module tb_time_set_controller;

  localparam int unsigned D   = 4;
  localparam int unsigned RD  = 3;
  localparam int unsigned RR  = 1;
  localparam int unsigned BT  = 2;
  localparam int unsigned TP  = 4;
  // Negedge-driven key change at cycle c shows its pulse at cycle c + LAT.
  localparam int unsigned LAT = D + 4;

  localparam int unsigned K_MIN  = 0;
  localparam int unsigned K_HOUR = 1;
  localparam int unsigned K_CLR  = 2;
  localparam int unsigned K_NONE = 3;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_add  = 1'b1;
  logic       tick_in  = 1'b0;
  logic [1:0] mode;
  logic       run_enable;
  logic       minute_inc;
  logic       hour_inc;
  logic       second_clear;
  logic       blank_minute;
  logic       blank_hour;

  typedef struct {
    int unsigned cyc;
    int unsigned kind;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [2:0]  mon_pv;
  int unsigned cyc        = 0;
  int unsigned n_total    = 0;
  int unsigned n_pass     = 0;
  int unsigned n_inc_seen = 0;

  time_set_controller #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .BLINK_TICKS    (BT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_key_mode    (key_mode),
    .i_key_add     (key_add),
    .i_tick_in     (tick_in),
    .o_mode        (mode),
    .o_run_enable  (run_enable),
    .o_minute_inc  (minute_inc),
    .o_hour_inc    (hour_inc),
    .o_second_clear(second_clear),
    .o_blank_minute(blank_minute),
    .o_blank_hour  (blank_hour)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Tick is sampled at every posedge whose cycle number is a multiple of TP.
  always @(negedge clock) tick_in = ((cyc % TP) == (TP - 1));

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      mon_pv = {second_clear, hour_inc, minute_inc};
      if (minute_inc || hour_inc) begin
        n_inc_seen++;
        n_total++;
        if (minute_inc && hour_inc)
          $display("FAIL one_increment cycle %0d got minute=1 hour=1 want at most one", cyc);
        else
          n_pass++;
      end
      for (int unsigned k = 0; k < 3; k++) begin
        if (mon_pv[k]) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pulse kind %0d at cycle %0d, want no pulse", k, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc !== cyc || mon_e.kind !== k)
              $display("FAIL pulse_order got kind %0d at cycle %0d want kind %0d at cycle %0d",
                       k, cyc, mon_e.kind, mon_e.cyc);
            else
              n_pass++;
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_total++;
    if (mode !== 2'd0) $display("FAIL reset_mode got %0d want 0", mode); else n_pass++;
    n_total++;
    if (run_enable !== 1'b1) $display("FAIL reset_run_enable got %0b want 1", run_enable); else n_pass++;
    n_total++;
    if ({minute_inc, hour_inc, second_clear} !== 3'b000)
      $display("FAIL reset_pulses got %b want 000", {minute_inc, hour_inc, second_clear});
    else n_pass++;
    n_total++;
    if ({blank_minute, blank_hour} !== 2'b00)
      $display("FAIL reset_blank got %b want 00", {blank_minute, blank_hour});
    else n_pass++;
    reset = 1'b1;
    repeat (12) @(negedge clock);
    n_total++;
    if (mode !== 2'd0 || run_enable !== 1'b1)
      $display("FAIL idle_after_reset got mode %0d run %0b want mode 0 run 1", mode, run_enable);
    else n_pass++;
  endtask

  task automatic press_mode(input logic [1:0] nxt);
    int unsigned c;
    logic [1:0]  prv;
    prv = nxt - 2'd1;
    @(negedge clock);
    key_mode = 1'b0;
    c = cyc;
    if (nxt == 2'd1) exp_q.push_back('{c + LAT, K_CLR});
    repeat (LAT - 1) @(negedge clock);
    n_total++;
    if (mode !== prv) $display("FAIL mode_early(%0d) got %0d want %0d", nxt, mode, prv); else n_pass++;
    @(negedge clock);
    n_total++;
    if (mode !== nxt) $display("FAIL mode_step(%0d) got %0d want %0d", nxt, mode, nxt); else n_pass++;
    n_total++;
    if (run_enable !== (nxt == 2'd0))
      $display("FAIL run_enable(%0d) got %0b want %0b", nxt, run_enable, (nxt == 2'd0));
    else n_pass++;
    repeat (6) @(negedge clock);
    key_mode = 1'b1;
    repeat (D + 8) @(negedge clock);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL mode_pending(%0d) got %0d left want 0", nxt, exp_q.size());
    else n_pass++;
  endtask

  // Hold the add key low for 'hold' clocks and queue the increments the
  // press and its auto-repeat must produce (kind K_NONE: none expected).
  task automatic add_press(input int unsigned hold, input int unsigned kind,
                           input bit bounce, output int unsigned n_exp);
    int unsigned c;
    int unsigned p;
    int unsigned last;
    int unsigned ticks;
    if (bounce) begin
      for (int unsigned b = 0; b < 4; b++) begin
        @(negedge clock);
        key_add = b[0];
        @(negedge clock);
      end
    end
    @(negedge clock);
    key_add = 1'b0;
    c     = cyc;
    p     = c + LAT;
    last  = c + hold + D + 2;
    n_exp = 0;
    ticks = 0;
    if (kind != K_NONE) begin
      exp_q.push_back('{p, kind});
      n_exp = 1;
      for (int unsigned e = p + 1; e <= last; e++) begin
        if ((e % TP) == 0) begin
          ticks++;
          if (ticks >= RD && ((ticks - RD) % RR) == 0) begin
            exp_q.push_back('{e, kind});
            n_exp++;
          end
        end
      end
    end
    repeat (hold) @(negedge clock);
    key_add = 1'b1;
    repeat (D + 10) @(negedge clock);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL add_pending got %0d left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_mode_enter();
    press_mode(2'd1);
  endtask

  task automatic test_bounce();
    int unsigned n0;
    int unsigned ne;
    n0 = n_inc_seen;
    add_press(8, K_MIN, 1'b1, ne);
    n_total++;
    if (n_inc_seen - n0 != ne) $display("FAIL bounce_count got %0d want %0d", n_inc_seen - n0, ne);
    else n_pass++;
  endtask

  task automatic test_blink();
    int unsigned c;
    int unsigned p;
    int unsigned ntk;
    logic        want;
    @(negedge clock);
    key_add = 1'b0;
    c = cyc;
    p = c + LAT;
    exp_q.push_back('{p, K_MIN});
    for (int unsigned i = 0; i < LAT + 25; i++) begin
      @(negedge clock);
      if (cyc == c + 8) key_add = 1'b1;
      if (cyc >= p) begin
        ntk = 0;
        for (int unsigned e = p + 1; e <= cyc; e++) if ((e % TP) == 0) ntk++;
        want = ((ntk / BT) % 2) == 1;
        n_total++;
        if (blank_minute !== want)
          $display("FAIL blank_minute cycle %0d got %0b want %0b", cyc, blank_minute, want);
        else n_pass++;
        n_total++;
        if (blank_hour !== 1'b0) $display("FAIL blank_hour_setmin got %0b want 0", blank_hour);
        else n_pass++;
      end
    end
    repeat (D + 8) @(negedge clock);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL blink_pending got %0d left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int unsigned c;
    int unsigned n0;
    n0 = n_inc_seen;
    @(negedge clock);
    key_mode = 1'b0;
    key_add  = 1'b0;
    c = cyc;
    repeat (LAT) @(negedge clock);
    n_total++;
    if (mode !== 2'd2) $display("FAIL both_mode got %0d want 2", mode); else n_pass++;
    repeat (24) @(negedge clock);
    key_mode = 1'b1;
    key_add  = 1'b1;
    repeat (D + 10) @(negedge clock);
    n_total++;
    if (n_inc_seen != n0) $display("FAIL both_no_inc got %0d want 0", n_inc_seen - n0); else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL both_pending got %0d left want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_auto_repeat();
    int unsigned n0;
    int unsigned ne;
    n0 = n_inc_seen;
    add_press(40, K_HOUR, 1'b0, ne);
    n_total++;
    if (n_inc_seen - n0 != ne) $display("FAIL repeat_count got %0d want %0d", n_inc_seen - n0, ne);
    else n_pass++;
  endtask

  task automatic test_mode_cycle();
    int unsigned n0;
    int unsigned ne;
    press_mode(2'd3);
    n0 = n_inc_seen;
    add_press(12, K_NONE, 1'b0, ne);
    n_total++;
    if ({blank_minute, blank_hour} !== 2'b00)
      $display("FAIL stop_blank got %b want 00", {blank_minute, blank_hour});
    else n_pass++;
    press_mode(2'd0);
    add_press(12, K_NONE, 1'b0, ne);
    n_total++;
    if (n_inc_seen != n0) $display("FAIL stop_show_no_inc got %0d want 0", n_inc_seen - n0); else n_pass++;
    press_mode(2'd1);
    press_mode(2'd2);
    press_mode(2'd3);
    press_mode(2'd0);
  endtask

  task automatic test_reset_mid_hold();
    int unsigned c;
    int unsigned rr;
    int unsigned n0;
    press_mode(2'd1);
    n0 = n_inc_seen;
    @(negedge clock);
    key_add = 1'b0;
    c = cyc;
    exp_q.push_back('{c + LAT, K_MIN});
    repeat (LAT + 6) @(negedge clock);
    reset    = 1'b0;
    key_mode = 1'b0;
    repeat (5) @(negedge clock);
    n_total++;
    if (mode !== 2'd0 || run_enable !== 1'b1 || {minute_inc, hour_inc, second_clear} !== 3'b000)
      $display("FAIL mid_reset_state got mode %0d run %0b pulses %b want 0 1 000",
               mode, run_enable, {minute_inc, hour_inc, second_clear});
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL mid_reset_pending got %0d left want 0", exp_q.size());
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    rr = cyc;
    exp_q.push_back('{rr + LAT, K_CLR});
    repeat (LAT - 1) @(negedge clock);
    n_total++;
    if (mode !== 2'd0) $display("FAIL held_through_reset_early got %0d want 0", mode); else n_pass++;
    @(negedge clock);
    n_total++;
    if (mode !== 2'd1) $display("FAIL held_through_reset_mode got %0d want 1", mode); else n_pass++;
    repeat (30) @(negedge clock);
    key_mode = 1'b1;
    key_add  = 1'b1;
    repeat (D + 10) @(negedge clock);
    n_total++;
    if (n_inc_seen - n0 != 1) $display("FAIL mid_reset_inc got %0d want 1", n_inc_seen - n0);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL held_reset_pending got %0d left want 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mode_enter();
    test_bounce();
    test_blink();
    test_simultaneous();
    test_auto_repeat();
    test_mode_cycle();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
